// File: rtl/cmp_branch_pkg.sv
// Shared opcodes, FSM encoding and status-flag layout for the compare/branch sequencer.
package cmp_branch_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CMP = 3'b001;
  localparam logic [2:0] OP_BEQ = 3'b010;
  localparam logic [2:0] OP_BNE = 3'b011;
  localparam logic [2:0] OP_BLT = 3'b100;
  localparam logic [2:0] OP_BGT = 3'b101;
  localparam logic [2:0] OP_BLE = 3'b110;
  localparam logic [2:0] OP_BGE = 3'b111;

  localparam int FLAG_LT = 0;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_GT = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CMP_DRIVE   = 3'd1,
    ST_CMP_CAPTURE = 3'd2,
    ST_BR_EVAL     = 3'd3,
    ST_RETIRE      = 3'd4
  } state_t;

  // A trustworthy comparator result asserts exactly one of lt/eq/gt.
  function automatic logic flags_one_hot(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch decision from the stored comparator status flags.
module branch_cond_eval
  import cmp_branch_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [2:0] flags,
  input  logic       flags_valid,
  output logic       taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (opcode)
      OP_BEQ:  cond = flags[FLAG_EQ];
      OP_BNE:  cond = !flags[FLAG_EQ];
      OP_BLT:  cond = flags[FLAG_LT];
      OP_BGT:  cond = flags[FLAG_GT];
      OP_BLE:  cond = flags[FLAG_LT] | flags[FLAG_EQ];
      OP_BGE:  cond = flags[FLAG_GT] | flags[FLAG_EQ];
      default: cond = 1'b0;
    endcase
    // Without a checked CMP result no branch may be taken.
    taken = flags_valid & cond;
  end

endmodule

// File: rtl/cmp_branch_sequencer.sv
// Issues CMP micro-ops to an external comparator, captures its flags, and
// resolves conditional branches against them into a PC-load pulse.
module cmp_branch_sequencer
  import cmp_branch_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_opcode,
  input  logic [DATA_W-1:0] i_operand1,
  input  logic [DATA_W-1:0] i_operand2,
  input  logic [ADDR_W-1:0] i_target,
  output logic [DATA_W-1:0] o_cmp_operand1,
  output logic [DATA_W-1:0] o_cmp_operand2,
  output logic              o_cmp_enable,
  input  logic              i_cmp_less,
  input  logic              i_cmp_equal,
  input  logic              i_cmp_greater,
  output logic [2:0]        o_flags,
  output logic              o_flags_valid,
  output logic              o_pc_load,
  output logic [ADDR_W-1:0] o_pc_target,
  output logic              o_flag_err,
  output logic              o_done
);

  state_t              state_q, state_d;
  logic                accept;
  logic [2:0]          op_p0;
  logic [ADDR_W-1:0]   target_p0;
  logic [DATA_W-1:0]   opa_p0, opb_p0;
  logic [2:0]          sample;
  logic [2:0]          flags_q;
  logic                flags_vld_q;
  logic                cap_err_q;
  logic                taken;

  assign accept = i_valid && (state_q == ST_IDLE);

  always_comb begin
    sample          = 3'b000;
    sample[FLAG_LT] = i_cmp_less;
    sample[FLAG_EQ] = i_cmp_equal;
    sample[FLAG_GT] = i_cmp_greater;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p0: micro-op latched on the accept edge
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_p0     <= i_opcode;
      target_p0 <= i_target;
    end
  end

  // Operands and status are visible outputs, so they clear on reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      opa_p0      <= '0;
      opb_p0      <= '0;
      flags_q     <= 3'b000;
      flags_vld_q <= 1'b0;
      cap_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        opa_p0 <= i_operand1;
        opb_p0 <= i_operand2;
      end
      if (state_q == ST_CMP_DRIVE) begin
        if (flags_one_hot(sample)) begin
          flags_q     <= sample;
          flags_vld_q <= 1'b1;
          cap_err_q   <= 1'b0;
        end else begin
          flags_vld_q <= 1'b0;
          cap_err_q   <= 1'b1;
        end
      end
    end
  end

  branch_cond_eval u_cond (
    .opcode      (op_p0),
    .flags       (flags_q),
    .flags_valid (flags_vld_q),
    .taken       (taken)
  );

  always_comb begin
    state_d      = state_q;
    o_ready      = 1'b0;
    o_cmp_enable = 1'b0;
    o_done       = 1'b0;
    o_pc_load    = 1'b0;
    o_pc_target  = '0;
    o_flag_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          case (i_opcode)
            OP_NOP:  state_d = ST_RETIRE;
            OP_CMP:  state_d = ST_CMP_DRIVE;
            default: state_d = ST_BR_EVAL;
          endcase
        end
      end
      ST_CMP_DRIVE: begin
        o_cmp_enable = 1'b1;
        state_d      = ST_CMP_CAPTURE;
      end
      ST_CMP_CAPTURE: begin
        o_done     = 1'b1;
        o_flag_err = cap_err_q;
        state_d    = ST_IDLE;
      end
      ST_BR_EVAL: begin
        o_done     = 1'b1;
        o_flag_err = !flags_vld_q;
        if (taken) begin
          o_pc_load   = 1'b1;
          o_pc_target = target_p0;
        end
        state_d = ST_IDLE;
      end
      ST_RETIRE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_cmp_operand1 = opa_p0;
  assign o_cmp_operand2 = opb_p0;
  assign o_flags        = flags_q;
  assign o_flags_valid  = flags_vld_q;

endmodule

// File: tb/tb_cmp_branch_sequencer.sv
// Directed bench for cmp_branch_sequencer with an in-bench comparator and outcome model.
module tb_cmp_branch_sequencer;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 8;

  localparam logic [2:0] C_NOP = 3'b000, C_CMP = 3'b001, C_BEQ = 3'b010, C_BNE = 3'b011,
                         C_BLT = 3'b100, C_BGT = 3'b101, C_BLE = 3'b110, C_BGE = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_opcode;
  logic [DATA_W-1:0] i_operand1, i_operand2;
  logic [ADDR_W-1:0] i_target;
  logic [DATA_W-1:0] o_cmp_operand1, o_cmp_operand2;
  logic              o_cmp_enable;
  logic              cmp_less, cmp_equal, cmp_greater;
  logic [2:0]        o_flags;
  logic              o_flags_valid, o_pc_load, o_flag_err, o_done;
  logic [ADDR_W-1:0] o_pc_target;

  always #5 clk = ~clk;

  cmp_branch_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_opcode       (i_opcode),
    .i_operand1     (i_operand1),
    .i_operand2     (i_operand2),
    .i_target       (i_target),
    .o_cmp_operand1 (o_cmp_operand1),
    .o_cmp_operand2 (o_cmp_operand2),
    .o_cmp_enable   (o_cmp_enable),
    .i_cmp_less     (cmp_less),
    .i_cmp_equal    (cmp_equal),
    .i_cmp_greater  (cmp_greater),
    .o_flags        (o_flags),
    .o_flags_valid  (o_flags_valid),
    .o_pc_load      (o_pc_load),
    .o_pc_target    (o_pc_target),
    .o_flag_err     (o_flag_err),
    .o_done         (o_done)
  );

  // External comparator; force_bad makes it report lt and gt together.
  logic force_bad;
  always_comb begin
    cmp_less    = 1'b0;
    cmp_equal   = 1'b0;
    cmp_greater = 1'b0;
    if (o_cmp_enable) begin
      if (force_bad) begin
        cmp_less    = 1'b1;
        cmp_greater = 1'b1;
      end else begin
        cmp_less    = o_cmp_operand1 <  o_cmp_operand2;
        cmp_equal   = o_cmp_operand1 == o_cmp_operand2;
        cmp_greater = o_cmp_operand1 >  o_cmp_operand2;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic              e_ready, e_en, e_fvalid, e_load, e_err, e_done;
  logic [DATA_W-1:0] e_op1, e_op2;
  logic [2:0]        e_flags;
  logic [ADDR_W-1:0] e_target;

  // Model: last good compare operands and whether a valid result is held.
  logic [DATA_W-1:0] ma, mb;
  logic [2:0]        mflags;
  logic              mvalid;

  logic              obs_load, obs_err, obs_done, obs_fvalid;
  logic [ADDR_W-1:0] obs_target;
  logic [2:0]        obs_flags;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready",      o_ready,       e_ready);
      chk("cmp_enable", o_cmp_enable,  e_en);
      chk("flags",      o_flags,       e_flags);
      chk("flags_vld",  o_flags_valid, e_fvalid);
      chk("pc_load",    o_pc_load,     e_load);
      chk("pc_target",  o_pc_target,   e_target);
      chk("flag_err",   o_flag_err,    e_err);
      chk("done",       o_done,        e_done);
      if (e_en) begin
        chk("cmp_op1", o_cmp_operand1, e_op1);
        chk("cmp_op2", o_cmp_operand2, e_op2);
      end
    end
  end

  task automatic set_idle();
    e_ready  = 1'b1;
    e_en     = 1'b0;
    e_op1    = '0;
    e_op2    = '0;
    e_load   = 1'b0;
    e_target = '0;
    e_err    = 1'b0;
    e_done   = 1'b0;
    e_flags  = mflags;
    e_fvalid = mvalid;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    obs_load   = o_pc_load;
    obs_target = o_pc_target;
    obs_err    = o_flag_err;
    obs_done   = o_done;
    obs_flags  = o_flags;
    obs_fvalid = o_flags_valid;
  endtask

  function automatic logic br_cond(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    case (op)
      C_BEQ:   return a == b;
      C_BNE:   return a != b;
      C_BLT:   return a <  b;
      C_BGT:   return a >  b;
      C_BLE:   return a <= b;
      C_BGE:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // hold keeps i_valid high during the busy cycles with a different op queued behind.
  task automatic do_cmp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit bad,
                        input bit hold, input logic [2:0] hold_op, input logic [ADDR_W-1:0] hold_tgt);
    logic err;
    i_valid = 1'b1; i_opcode = C_CMP; i_operand1 = a; i_operand2 = b; force_bad = bad;
    set_idle();
    cycle();
    if (hold) begin
      i_opcode = hold_op; i_target = hold_tgt; i_operand1 = ~a; i_operand2 = ~b;
    end else begin
      i_valid = 1'b0;
    end
    set_idle(); e_ready = 1'b0; e_en = 1'b1; e_op1 = a; e_op2 = b;
    cycle();
    if (!bad) begin
      mflags = {a > b, a == b, a < b};
      mvalid = 1'b1; ma = a; mb = b; err = 1'b0;
    end else begin
      mvalid = 1'b0; err = 1'b1;
    end
    set_idle(); e_ready = 1'b0; e_done = 1'b1; e_err = err;
    snap();
    cycle();
    force_bad = 1'b0;
    set_idle();
  endtask

  task automatic do_br(input logic [2:0] op, input logic [ADDR_W-1:0] tgt);
    logic tk;
    i_valid = 1'b1; i_opcode = op; i_target = tgt;
    set_idle();
    cycle();
    i_valid = 1'b0;
    tk = mvalid && br_cond(op, ma, mb);
    set_idle(); e_ready = 1'b0; e_done = 1'b1; e_load = tk;
    e_target = tk ? tgt : '0; e_err = !mvalid;
    snap();
    cycle();
    set_idle();
  endtask

  task automatic do_nop();
    i_valid = 1'b1; i_opcode = C_NOP; i_target = 8'hEE;
    set_idle();
    cycle();
    i_valid = 1'b0;
    set_idle(); e_ready = 1'b0; e_done = 1'b1;
    snap();
    cycle();
    set_idle();
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_opcode = C_NOP; i_operand1 = '0; i_operand2 = '0;
    i_target = '0; force_bad = 1'b0;
    mflags = 3'b000; mvalid = 1'b0; ma = '0; mb = '0;
    set_idle();
    #1;
    chk_on = 1'b1;
    repeat (2) cycle();
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_flags_vld", o_flags_valid, 1'b0);
    rst = 1'b0;
    cycle();

    do_nop();
    chk("nop_done", obs_done, 1'b1);

    do_br(C_BEQ, 8'h55);
    chk("noflag_err", obs_err, 1'b1);
    chk("noflag_load", obs_load, 1'b0);

    do_cmp(4'd3, 4'd9, 1'b0, 1'b0, C_NOP, '0);
    chk("cmp3v9_flags", obs_flags, 3'b001);
    chk("cmp3v9_vld", obs_fvalid, 1'b1);

    do_cmp(4'd5, 4'd5, 1'b0, 1'b0, C_NOP, '0);
    do_br(C_BEQ, 8'h2A);
    chk("beq_load", obs_load, 1'b1);
    chk("beq_target", obs_target, 8'h2A);
    do_br(C_BNE, 8'h2B);
    chk("bne_load", obs_load, 1'b0);
    chk("bne_done", obs_done, 1'b1);

    do_cmp(4'd12, 4'd4, 1'b0, 1'b0, C_NOP, '0);
    do_br(C_BGE, 8'h10);
    chk("bge_load", obs_load, 1'b1);
    chk("bge_target", obs_target, 8'h10);
    do_br(C_BLE, 8'h20);
    chk("ble_load", obs_load, 1'b0);
    do_br(C_BLT, 8'h30);
    chk("blt_target", obs_target, 8'h00);
    do_br(C_BGT, 8'h40);

    // Async reset asserted mid-cycle while the comparator is being driven.
    i_valid = 1'b1; i_opcode = C_CMP; i_operand1 = 4'd7; i_operand2 = 4'd2;
    set_idle();
    cycle();
    i_valid = 1'b0;
    set_idle(); e_ready = 1'b0; e_en = 1'b1; e_op1 = 4'd7; e_op2 = 4'd2;
    #2;
    rst = 1'b1;
    mflags = 3'b000; mvalid = 1'b0;
    set_idle();
    #1;
    chk("midrst_ready", o_ready, 1'b1);
    chk("midrst_enable", o_cmp_enable, 1'b0);
    chk("midrst_flags_vld", o_flags_valid, 1'b0);
    chk("midrst_op1", o_cmp_operand1, 4'd0);
    cycle();
    rst = 1'b0;
    cycle();

    do_cmp(4'd12, 4'd4, 1'b0, 1'b0, C_NOP, '0);
    do_cmp(4'd1, 4'd2, 1'b1, 1'b0, C_NOP, '0);
    chk("bad_err", obs_err, 1'b1);
    chk("bad_vld", obs_fvalid, 1'b0);
    chk("bad_flags_kept", obs_flags, 3'b100);
    do_br(C_BEQ, 8'h77);
    chk("bad_beq_load", obs_load, 1'b0);
    chk("bad_beq_err", obs_err, 1'b1);
    do_br(C_BGT, 8'h78);

    do_cmp(4'd6, 4'd6, 1'b0, 1'b1, C_BEQ, 8'h5A);
    do_br(C_BEQ, 8'h5A);
    chk("held_beq_load", obs_load, 1'b1);

    do_cmp(4'd15, 4'd0, 1'b0, 1'b0, C_NOP, '0);
    do_br(C_BNE, 8'hFF);
    chk("max_bne_target", obs_target, 8'hFF);
    do_br(C_BLE, 8'h01);
    do_cmp(4'd0, 4'd15, 1'b0, 1'b0, C_NOP, '0);
    do_br(C_BLT, 8'h81);
    cycle();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
